branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer with saturating direction counters for the 5-stage MIPS pipeline. It predicts next-PC in IF so taken branches and jumps no longer always cost an EX-stage flush. It trains on resolutions from EX and produces the mispredict/redirect signal that drives IF/ID and ID/EX flush.

---
 rtl/branch_target_buffer.sv | 133 +++++++++++++
 tb/tb_branch_target_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CTR_W   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] IF_PC,
  output logic              IF_PredTaken,
  output logic [DATA_W-1:0] IF_PredNextPC,
  input  logic              EX_Valid,
  input  logic [DATA_W-1:0] EX_PC,
  input  logic              EX_Taken,
  input  logic [DATA_W-1:0] EX_Target,
  input  logic              EX_PredTaken,
  input  logic [DATA_W-1:0] EX_PredNextPC,
  output logic              Mispredict,
  output logic [DATA_W-1:0] CorrectPC,
  input  logic              BTB_Flush,
  output logic [31:0]       StatResolved,
  output logic [31:0]       StatMispredict
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = DATA_W - INDEX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == '1) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit;
  logic [DATA_W-1:0]  if_pc_plus4, ex_pc_plus4;

  // PC bits [1:0] and the carried prediction bit are not needed by this table.
  logic unused_inputs;
  assign unused_inputs = ^{IF_PC[1:0], EX_PC[1:0], EX_PredTaken};

  assign if_idx      = IF_PC[INDEX_W+1:2];
  assign if_tag      = IF_PC[DATA_W-1:INDEX_W+2];
  assign ex_idx      = EX_PC[INDEX_W+1:2];
  assign ex_tag      = EX_PC[DATA_W-1:INDEX_W+2];
  assign if_pc_plus4 = IF_PC + DATA_W'(4);
  assign ex_pc_plus4 = EX_PC + DATA_W'(4);

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign IF_PredTaken  = if_hit && ctr_q[if_idx][CTR_W-1];
  assign IF_PredNextPC = IF_PredTaken ? target_q[if_idx] : if_pc_plus4;

  assign CorrectPC  = EX_Taken ? EX_Target : ex_pc_plus4;
  assign Mispredict = EX_Valid && (CorrectPC != EX_PredNextPC);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (BTB_Flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (EX_Valid) begin
      if (ex_hit) begin
        if (EX_Taken) begin
          ctr_q[ex_idx]    <= ctr_inc(ctr_q[ex_idx]);
          target_q[ex_idx] <= EX_Target;
        end else begin
          ctr_q[ex_idx] <= ctr_dec(ctr_q[ex_idx]);
        end
      end else if (EX_Taken) begin
        // Allocation replaces whatever aliased into this slot.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= EX_Target;
        ctr_q[ex_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BTB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_res_q, stat_res_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (EX_Valid)   stat_res_d = sat_inc32(stat_res_q);
    if (Mispredict) stat_mis_d = sat_inc32(stat_mis_q);
  end

  // Statistics survive BTB_Flush; only Reset clears them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign StatResolved   = stat_res_q;
  assign StatMispredict = stat_mis_q;
`else
  assign StatResolved   = 32'd0;
  assign StatMispredict = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (default parameters).
// Define BTB_STATS_EN for both bench and RTL to exercise the statistics counters.
module tb_branch_target_buffer;

  logic        Clk;
  logic        Reset;
  logic [31:0] IF_PC;
  logic        IF_PredTaken;
  logic [31:0] IF_PredNextPC;
  logic        EX_Valid;
  logic [31:0] EX_PC;
  logic        EX_Taken;
  logic [31:0] EX_Target;
  logic        EX_PredTaken;
  logic [31:0] EX_PredNextPC;
  logic        Mispredict;
  logic [31:0] CorrectPC;
  logic        BTB_Flush;
  logic [31:0] StatResolved;
  logic [31:0] StatMispredict;

  branch_target_buffer #(.DATA_W(32), .INDEX_W(4), .CTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .IF_PC(IF_PC),
    .IF_PredTaken(IF_PredTaken), .IF_PredNextPC(IF_PredNextPC),
    .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_Taken(EX_Taken),
    .EX_Target(EX_Target), .EX_PredTaken(EX_PredTaken),
    .EX_PredNextPC(EX_PredNextPC), .Mispredict(Mispredict),
    .CorrectPC(CorrectPC), .BTB_Flush(BTB_Flush),
    .StatResolved(StatResolved), .StatMispredict(StatMispredict)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam int S_PT = 0, S_NPC = 1, S_MIS = 2, S_CPC = 3, S_SRES = 4, S_SMIS = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_res  = 0;
  int   exp_mis  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_out(input int sel);
    case (sel)
      S_PT:    return {31'd0, IF_PredTaken};
      S_NPC:   return IF_PredNextPC;
      S_MIS:   return {31'd0, Mispredict};
      S_CPC:   return CorrectPC;
      S_SRES:  return StatResolved;
      default: return StatMispredict;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_look(input string tag, input logic pt, input logic [31:0] npc);
    push({tag, "_pt"}, S_PT, {31'd0, pt});
    push({tag, "_npc"}, S_NPC, npc);
  endtask

  task automatic push_stats(input string tag);
`ifdef BTB_STATS_EN
    push({tag, "_sres"}, S_SRES, exp_res);
    push({tag, "_smis"}, S_SMIS, exp_mis);
`else
    push({tag, "_sres"}, S_SRES, 32'd0);
    push({tag, "_smis"}, S_SMIS, 32'd0);
`endif
  endtask

  // Compare everything queued against the DUT at mid-cycle.
  task automatic check_sb();
    exp_t e;
    @(negedge Clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, dut_out(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    EX_Valid  = 1'b0;
    BTB_Flush = 1'b0;
  endtask

  task automatic set_ex(input string tag, input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic [31:0] pnext,
                        input logic mis, input logic [31:0] cpc);
    EX_Valid      = 1'b1;
    EX_PC         = pc;
    EX_Taken      = taken;
    EX_Target     = tgt;
    EX_PredNextPC = pnext;
    EX_PredTaken  = (pnext != pc + 32'd4);
    push({tag, "_mis"}, S_MIS, {31'd0, mis});
    push({tag, "_cpc"}, S_CPC, cpc);
    exp_res++;
    if (mis) exp_mis++;
  endtask

  // Resolve one branch while IF looks up IF_PC; check lookup before and after the edge.
  task automatic upd_look(input string tag, input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic [31:0] pnext,
                          input logic mis, input logic [31:0] cpc,
                          input logic pt_pre, input logic [31:0] npc_pre,
                          input logic pt_post, input logic [31:0] npc_post);
    set_ex(tag, pc, taken, tgt, pnext, mis, cpc);
    push_look({tag, "_pre"}, pt_pre, npc_pre);
    check_sb();
    cyc();
    push_look({tag, "_post"}, pt_post, npc_post);
    check_sb();
    cyc();
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic pt, input logic [31:0] npc);
    IF_PC = pc;
    push_look(tag, pt, npc);
    check_sb();
    cyc();
  endtask

  initial begin
    Reset = 1'b1; IF_PC = 32'h0040_0000; EX_Valid = 1'b0; EX_PC = '0;
    EX_Taken = 1'b0; EX_Target = '0; EX_PredTaken = 1'b0; EX_PredNextPC = '0;
    BTB_Flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Post-reset state
    push_look("rst", 1'b0, 32'h0040_0004);
    push("rst_mis", S_MIS, 32'd0);
    push_stats("rst");
    check_sb();
    cyc();

    // First taken resolution allocates
    upd_look("alloc", 32'h0040_0010, 1'b1, 32'h0040_0040, 32'h0040_0014, 1'b1, 32'h0040_0040,
             1'b0, 32'h0040_0004, 1'b0, 32'h0040_0004);
    lookup("alloc_hit", 32'h0040_0010, 1'b1, 32'h0040_0040);

    // Counter training on 0x00400010: 2->1->0->0->1->2->3->3->2->1
    upd_look("nt1", 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0040, 1'b1, 32'h0040_0014,
             1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
    upd_look("nt2", 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0040, 1'b1, 32'h0040_0014,
             1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
    upd_look("nt_sat", 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0014, 1'b0, 32'h0040_0014,
             1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
    upd_look("t1", 32'h0040_0010, 1'b1, 32'h0040_0040, 32'h0040_0014, 1'b1, 32'h0040_0040,
             1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
    upd_look("t2", 32'h0040_0010, 1'b1, 32'h0040_0040, 32'h0040_0014, 1'b1, 32'h0040_0040,
             1'b0, 32'h0040_0014, 1'b1, 32'h0040_0040);
    upd_look("t_newtgt", 32'h0040_0010, 1'b1, 32'h0040_0080, 32'h0040_0040, 1'b1, 32'h0040_0080,
             1'b1, 32'h0040_0040, 1'b1, 32'h0040_0080);
    upd_look("t_sat", 32'h0040_0010, 1'b1, 32'h0040_0080, 32'h0040_0080, 1'b0, 32'h0040_0080,
             1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
    upd_look("nt3", 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0080, 1'b1, 32'h0040_0014,
             1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
    upd_look("nt4", 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0080, 1'b1, 32'h0040_0014,
             1'b1, 32'h0040_0080, 1'b0, 32'h0040_0014);

    // Aliasing: 0x00400050 shares index 4 and evicts 0x00400010
    upd_look("alias", 32'h0040_0050, 1'b1, 32'h0040_0100, 32'h0040_0054, 1'b1, 32'h0040_0100,
             1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
    lookup("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0100);

    // PC+4 wraps at the top of the address space; not-taken miss allocates nothing
    IF_PC = 32'hFFFF_FFFC;
    upd_look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 32'h0000_0000,
             1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);

    // Same-cycle lookup and update of one entry: no bypass
    IF_PC = 32'h0040_0020;
    upd_look("same", 32'h0040_0020, 1'b1, 32'h0040_0200, 32'h0040_0024, 1'b1, 32'h0040_0200,
             1'b0, 32'h0040_0024, 1'b1, 32'h0040_0200);
    push_stats("pre_flush");
    check_sb();
    cyc();

    // Flush wins over a concurrent taken update
    BTB_Flush = 1'b1;
    set_ex("flush", 32'h0040_0030, 1'b1, 32'h0040_0300, 32'h0040_0034, 1'b1, 32'h0040_0300);
    push_look("flush_pre", 1'b1, 32'h0040_0200);
    check_sb();
    cyc();
    lookup("flush_20", 32'h0040_0020, 1'b0, 32'h0040_0024);
    lookup("flush_30", 32'h0040_0030, 1'b0, 32'h0040_0034);
    lookup("flush_50", 32'h0040_0050, 1'b0, 32'h0040_0054);
    push_stats("post_flush");
    check_sb();
    cyc();

    // Reset beats concurrent flush and update; Mispredict still follows EX inputs
    Reset     = 1'b1;
    BTB_Flush = 1'b1;
    set_ex("rst_upd", 32'h0040_0040, 1'b1, 32'h0040_0400, 32'h0040_0044, 1'b1, 32'h0040_0400);
    check_sb();
    cyc();
    Reset   = 1'b0;
    exp_res = 0;
    exp_mis = 0;
    lookup("rst_upd_look", 32'h0040_0040, 1'b0, 32'h0040_0044);
    push_stats("rst2");
    check_sb();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
